// File: rtl/lamp_pkg.sv
// Shared types and defaults for the multi-channel lamp controller.
//   auto_state_t  : auto-light (CDS) state machine states
//   blink_state_t : turn/hazard blinker states
//   DEF_LVL_*     : default PWM duty levels for tail, reverse and brake
package lamp_pkg;

    typedef enum logic [1:0] {
        AUTO_BRIGHT      = 2'd0,
        AUTO_DARK_PEND   = 2'd1,
        AUTO_DARK        = 2'd2,
        AUTO_BRIGHT_PEND = 2'd3
    } auto_state_t;

    typedef enum logic [1:0] {
        BLINK_IDLE = 2'd0,
        BLINK_ON   = 2'd1,
        BLINK_OFF  = 2'd2
    } blink_state_t;

    localparam int unsigned DEF_LVL_TAIL  = 77;
    localparam int unsigned DEF_LVL_REV   = 179;
    localparam int unsigned DEF_LVL_BRAKE = 255;

    // The driver-visible "dark" flag covers both settled dark and the
    // pending return to bright.
    function automatic logic is_dark_state(input auto_state_t s);
        return (s == AUTO_DARK) || (s == AUTO_BRIGHT_PEND);
    endfunction

endpackage

// File: rtl/lamp_fader.sv
// One tail-lamp channel: picks a target level, ramps the level register
// toward it on fade ticks (brake snaps up instantly) and drives a PWM bit.
// Ports:
//   clk, rst    : clock, async active-high reset
//   rev_sel     : this channel is a reverse lamp and gear R is engaged
//   is_brake    : brake pressed
//   head_on     : headlights (and thus tail lamps) on
//   pwm_cnt     : shared free-running PWM counter
//   fade_tick   : one-cycle pulse every FADE_DIV clk
//   pwm         : registered PWM drive for this channel
module lamp_fader
    import lamp_pkg::*;
#(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned LVL_TAIL  = DEF_LVL_TAIL,
    parameter int unsigned LVL_REV   = DEF_LVL_REV,
    parameter int unsigned LVL_BRAKE = DEF_LVL_BRAKE,
    parameter int unsigned FADE_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rev_sel,
    input  logic                is_brake,
    input  logic                head_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                fade_tick,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] TAIL_V  = PWM_BITS'(LVL_TAIL);
    localparam logic [PWM_BITS-1:0] REV_V   = PWM_BITS'(LVL_REV);
    localparam logic [PWM_BITS-1:0] BRAKE_V = PWM_BITS'(LVL_BRAKE);
    localparam logic [PWM_BITS-1:0] STEP_V  = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;

    // Target select: reverse beats brake beats tail.
    always_comb begin
        target = '0;
        if (rev_sel) begin
            target = REV_V;
        end else if (is_brake) begin
            target = BRAKE_V;
        end else if (head_on) begin
            target = TAIL_V;
        end
    end

    // Ramp toward target, clamping the final step; brake rises without fading.
    always_comb begin
        level_nxt = level;
        if ((target == BRAKE_V) && (level < target)) begin
            level_nxt = target;
        end else if (fade_tick) begin
            if (level < target) begin
                level_nxt = ((target - level) <= STEP_V) ? target : level + STEP_V;
            end else if (level > target) begin
                level_nxt = ((level - target) <= STEP_V) ? target : level - STEP_V;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            pwm   <= 1'b0;
        end else begin
            level <= level_nxt;
            pwm   <= (pwm_cnt < level) | (&level);
        end
    end

endmodule

// File: rtl/lamp_ctrl_multi.sv
// Multi-channel lamp controller: debounced auto-light, headlights,
// N_TAIL faded tail/brake/reverse PWM channels and turn/hazard blinker.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   sw_headlight, sw_high_beam : driver switches
//   cds_val                  : light sensor reading (lower = darker)
//   is_brake, is_reverse     : vehicle state
//   turn_left, turn_right, hazard : indicator requests
//   head_low, head_high      : headlight drives (registered)
//   tail_pwm                 : per-channel tail PWM (registered)
//   turn_l_out, turn_r_out   : indicator lamps (registered)
//   is_dark                  : auto-light state (registered)
module lamp_ctrl_multi
    import lamp_pkg::*;
#(
    parameter int unsigned        N_TAIL     = 4,
    parameter logic [N_TAIL-1:0]  REV_MASK   = N_TAIL'(4'b0110),
    parameter int unsigned        PWM_BITS   = 8,
    parameter int unsigned        LVL_TAIL   = DEF_LVL_TAIL,
    parameter int unsigned        LVL_REV    = DEF_LVL_REV,
    parameter int unsigned        LVL_BRAKE  = DEF_LVL_BRAKE,
    parameter int unsigned        FADE_DIV   = 1024,
    parameter int unsigned        FADE_STEP  = 8,
    parameter int unsigned        DARK_ON    = 240,
    parameter int unsigned        DARK_OFF   = 250,
    parameter int unsigned        DWELL      = 4096,
    parameter int unsigned        BLINK_HALF = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_headlight,
    input  logic              sw_high_beam,
    input  logic [7:0]        cds_val,
    input  logic              is_brake,
    input  logic              is_reverse,
    input  logic              turn_left,
    input  logic              turn_right,
    input  logic              hazard,
    output logic              head_low,
    output logic              head_high,
    output logic [N_TAIL-1:0] tail_pwm,
    output logic              turn_l_out,
    output logic              turn_r_out,
    output logic              is_dark
);

    localparam int unsigned DWELL_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam int unsigned FDIV_W  = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    localparam logic [7:0]         DARK_ON_V  = 8'(DARK_ON);
    localparam logic [7:0]         DARK_OFF_V = 8'(DARK_OFF);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [FDIV_W-1:0]  FDIV_LAST  = FDIV_W'(FADE_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    auto_state_t         auto_q, auto_nxt;
    logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
    logic                head_on;

    blink_state_t        blink_q, blink_nxt;
    logic [BLINK_W-1:0]  bcnt_q, bcnt_nxt;
    logic                blink_req;
    logic                lit_l, lit_r;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FDIV_W-1:0]   fdiv_q;
    logic                fade_tick;

    // Auto-light next state; the dwell counter is pre-incremented so that
    // DWELL consecutive samples (including the one that left the settled
    // state) are needed to flip is_dark.
    always_comb begin
        auto_nxt  = auto_q;
        dwell_nxt = dwell_q;
        case (auto_q)
            AUTO_BRIGHT: begin
                if (cds_val < DARK_ON_V) begin
                    auto_nxt  = AUTO_DARK_PEND;
                    dwell_nxt = '0;
                end
            end
            AUTO_DARK_PEND: begin
                if (cds_val >= DARK_ON_V) begin
                    auto_nxt = AUTO_BRIGHT;
                end else begin
                    dwell_nxt = dwell_q + DWELL_W'(1);
                    if (dwell_nxt == DWELL_LAST) begin
                        auto_nxt = AUTO_DARK;
                    end
                end
            end
            AUTO_DARK: begin
                if (cds_val > DARK_OFF_V) begin
                    auto_nxt  = AUTO_BRIGHT_PEND;
                    dwell_nxt = '0;
                end
            end
            AUTO_BRIGHT_PEND: begin
                if (cds_val <= DARK_OFF_V) begin
                    auto_nxt = AUTO_DARK;
                end else begin
                    dwell_nxt = dwell_q + DWELL_W'(1);
                    if (dwell_nxt == DWELL_LAST) begin
                        auto_nxt = AUTO_BRIGHT;
                    end
                end
            end
            default: auto_nxt = AUTO_BRIGHT;
        endcase
    end

    // Headlights follow the auto-light decision in the same cycle it lands.
    assign head_on = sw_headlight | is_dark_state(auto_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_q    <= AUTO_BRIGHT;
            dwell_q   <= '0;
            is_dark   <= 1'b0;
            head_low  <= 1'b0;
            head_high <= 1'b0;
        end else begin
            auto_q    <= auto_nxt;
            dwell_q   <= dwell_nxt;
            is_dark   <= is_dark_state(auto_nxt);
            head_low  <= head_on;
            head_high <= head_on & sw_high_beam;
        end
    end

    // Blinker next state; dropping every request returns to IDLE at once.
    assign blink_req = turn_left | turn_right | hazard;
    assign lit_l     = hazard | turn_left;
    assign lit_r     = hazard | turn_right;

    always_comb begin
        blink_nxt = blink_q;
        bcnt_nxt  = bcnt_q;
        if (!blink_req) begin
            blink_nxt = BLINK_IDLE;
            bcnt_nxt  = '0;
        end else begin
            case (blink_q)
                BLINK_IDLE: begin
                    blink_nxt = BLINK_ON;
                    bcnt_nxt  = '0;
                end
                BLINK_ON: begin
                    if (bcnt_q == BLINK_LAST) begin
                        blink_nxt = BLINK_OFF;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt_q + BLINK_W'(1);
                    end
                end
                BLINK_OFF: begin
                    if (bcnt_q == BLINK_LAST) begin
                        blink_nxt = BLINK_ON;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt_q + BLINK_W'(1);
                    end
                end
                default: begin
                    blink_nxt = BLINK_IDLE;
                    bcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q    <= BLINK_IDLE;
            bcnt_q     <= '0;
            turn_l_out <= 1'b0;
            turn_r_out <= 1'b0;
        end else begin
            blink_q    <= blink_nxt;
            bcnt_q     <= bcnt_nxt;
            turn_l_out <= (blink_nxt == BLINK_ON) & lit_l;
            turn_r_out <= (blink_nxt == BLINK_ON) & lit_r;
        end
    end

    // Shared PWM counter and fade-tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            fdiv_q    <= '0;
            fade_tick <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (fdiv_q == FDIV_LAST) begin
                fdiv_q    <= '0;
                fade_tick <= 1'b1;
            end else begin
                fdiv_q    <= fdiv_q + FDIV_W'(1);
                fade_tick <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < int'(N_TAIL); i++) begin : g_ch
        lamp_fader #(
            .PWM_BITS  (PWM_BITS),
            .LVL_TAIL  (LVL_TAIL),
            .LVL_REV   (LVL_REV),
            .LVL_BRAKE (LVL_BRAKE),
            .FADE_STEP (FADE_STEP)
        ) u_fader (
            .clk       (clk),
            .rst       (rst),
            .rev_sel   (REV_MASK[i] & is_reverse),
            .is_brake  (is_brake),
            .head_on   (head_on),
            .pwm_cnt   (pwm_cnt),
            .fade_tick (fade_tick),
            .pwm       (tail_pwm[i])
        );
    end

endmodule

// File: tb/tb_lamp_ctrl_multi.sv
// Self-checking bench for lamp_ctrl_multi with shortened fade and blink timing.
module tb_lamp_ctrl_multi;

    localparam int unsigned N_TAIL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sw_headlight, sw_high_beam;
    logic [7:0]        cds_val;
    logic              is_brake, is_reverse;
    logic              turn_left, turn_right, hazard;
    logic              head_low, head_high;
    logic [N_TAIL-1:0] tail_pwm;
    logic              turn_l_out, turn_r_out, is_dark;

    int n_cmp = 0;
    int n_err = 0;
    int duty [N_TAIL];

    typedef struct {
        logic hl, hb, tl, tr, hz;
        logic e_low, e_high, e_l, e_r;
    } vec_t;

    vec_t vecs [7];

    lamp_ctrl_multi #(
        .N_TAIL     (N_TAIL),
        .REV_MASK   (4'b0110),
        .PWM_BITS   (8),
        .LVL_TAIL   (77),
        .LVL_REV    (179),
        .LVL_BRAKE  (255),
        .FADE_DIV   (64),
        .FADE_STEP  (8),
        .DARK_ON    (240),
        .DARK_OFF   (250),
        .DWELL      (4096),
        .BLINK_HALF (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_headlight (sw_headlight),
        .sw_high_beam (sw_high_beam),
        .cds_val      (cds_val),
        .is_brake     (is_brake),
        .is_reverse   (is_reverse),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .hazard       (hazard),
        .head_low     (head_low),
        .head_high    (head_high),
        .tail_pwm     (tail_pwm),
        .turn_l_out   (turn_l_out),
        .turn_r_out   (turn_r_out),
        .is_dark      (is_dark)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        sw_headlight = 1'b0;
        sw_high_beam = 1'b0;
        cds_val      = 8'd255;
        is_brake     = 1'b0;
        is_reverse   = 1'b0;
        turn_left    = 1'b0;
        turn_right   = 1'b0;
        hazard       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // High cycles per channel over one full PWM period.
    task automatic measure();
        for (int c = 0; c < int'(N_TAIL); c++) duty[c] = 0;
        for (int n = 0; n < 256; n++) begin
            tick(1);
            for (int c = 0; c < int'(N_TAIL); c++) begin
                if (tail_pwm[c]) duty[c]++;
            end
        end
    endtask

    task automatic check_duty(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        int exp [N_TAIL];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        measure();
        for (int c = 0; c < int'(N_TAIL); c++) begin
            check($sformatf("%s_ch%0d", tag, c), duty[c], exp[c]);
        end
    endtask

    initial begin
        int bad;
        int zeros;

        //            hl    hb    tl    tr    hz    low   high  l     r
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        clear_inputs();
        rst = 1'b1;
        #1;
        check("rst_async_head_low", int'(head_low), 0);
        tick(2);
        check("rst_head_high", int'(head_high), 0);
        check("rst_tail_pwm", int'(tail_pwm), 0);
        check("rst_turn_l", int'(turn_l_out), 0);
        check("rst_turn_r", int'(turn_r_out), 0);
        check("rst_is_dark", int'(is_dark), 0);
        rst = 1'b0;

        // Headlight and indicator lit-set table, each applied from blinker IDLE.
        for (int v = 0; v < 7; v++) begin
            sw_headlight = vecs[v].hl;
            sw_high_beam = vecs[v].hb;
            turn_left    = vecs[v].tl;
            turn_right   = vecs[v].tr;
            hazard       = vecs[v].hz;
            tick(1);
            check($sformatf("vec%0d_head_low", v), int'(head_low), int'(vecs[v].e_low));
            check($sformatf("vec%0d_head_high", v), int'(head_high), int'(vecs[v].e_high));
            check($sformatf("vec%0d_turn_l", v), int'(turn_l_out), int'(vecs[v].e_l));
            check($sformatf("vec%0d_turn_r", v), int'(turn_r_out), int'(vecs[v].e_r));
            clear_inputs();
            tick(1);
        end

        // Threshold reading is not dark.
        do_reset();
        cds_val = 8'd240;
        tick(4200);
        check("cds240_not_dark", int'(is_dark), 0);

        // Dark after exactly DWELL samples, then hysteresis holds it.
        do_reset();
        cds_val = 8'd200;
        tick(4095);
        check("dwell_early_is_dark", int'(is_dark), 0);
        check("dwell_early_head_low", int'(head_low), 0);
        tick(1);
        check("dwell_is_dark", int'(is_dark), 1);
        check("dwell_head_low", int'(head_low), 1);
        cds_val = 8'd245;
        bad = 0;
        for (int n = 0; n < 10000; n++) begin
            tick(1);
            if (is_dark !== 1'b1) bad++;
        end
        check("hysteresis_cycles_not_dark", bad, 0);
        cds_val = 8'd255;
        tick(4095);
        check("bright_early_is_dark", int'(is_dark), 1);
        tick(1);
        check("bright_is_dark", int'(is_dark), 0);

        // A single bright glitch restarts the dwell.
        do_reset();
        cds_val = 8'd200;
        tick(3000);
        cds_val = 8'd255;
        tick(1);
        cds_val = 8'd200;
        tick(4095);
        check("glitch_early_is_dark", int'(is_dark), 0);
        tick(1);
        check("glitch_is_dark", int'(is_dark), 1);

        // Tail fade-in from 0, then brake snap.
        do_reset();
        sw_headlight = 1'b1;
        zeros = 0;
        for (int n = 0; n < 32; n++) begin
            tick(1);
            if (tail_pwm != '0) zeros++;
        end
        check("fade_start_cycles_nonzero", zeros, 0);
        tick(700);
        check_duty("tail", 77, 77, 77, 77);
        is_brake = 1'b1;
        tick(2);
        check_duty("brake", 256, 256, 256, 256);

        // Reverse on reverse-capable channels, then brake release.
        is_reverse = 1'b1;
        tick(800);
        check_duty("rev_brake", 256, 179, 179, 256);
        is_brake = 1'b0;
        tick(1600);
        check_duty("rev_tail", 77, 179, 179, 77);

        // Blink train, hazard joins mid-ON, then all requests drop.
        do_reset();
        turn_left = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int exp_l;
            int exp_r;
            tick(1);
            exp_l = (((k / 16) % 2) == 0) ? 1 : 0;
            exp_r = (k >= 6) ? exp_l : 0;
            check($sformatf("blink_l_k%0d", k), int'(turn_l_out), exp_l);
            check($sformatf("blink_r_k%0d", k), int'(turn_r_out), exp_r);
            if (k == 5) hazard = 1'b1;
        end
        turn_left = 1'b0;
        hazard    = 1'b0;
        tick(1);
        check("drop_turn_l", int'(turn_l_out), 0);
        check("drop_turn_r", int'(turn_r_out), 0);
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            tick(1);
            if (turn_l_out || turn_r_out) bad++;
        end
        check("idle_lamp_cycles", bad, 0);

        // Asynchronous reset in the middle of a fade and a blink.
        do_reset();
        sw_headlight = 1'b1;
        turn_left    = 1'b1;
        tick(300);
        check("pre_rst_turn_l", int'(turn_l_out), 1);
        check("pre_rst_head_low", int'(head_low), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_head_low", int'(head_low), 0);
        check("mid_rst_tail_pwm", int'(tail_pwm), 0);
        check("mid_rst_turn_l", int'(turn_l_out), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("post_rst_turn_l", int'(turn_l_out), 1);
        zeros = (tail_pwm != '0) ? 1 : 0;
        for (int n = 0; n < 31; n++) begin
            tick(1);
            if (tail_pwm != '0) zeros++;
        end
        check("post_rst_fade_cycles_nonzero", zeros, 0);
        tick(700);
        check_duty("post_rst_tail", 77, 77, 77, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
